// File: rtl/decoder38_seq.sv
// Registered 3-to-8 one-hot decoder with a small code FIFO.
// Each code drives y for max(hold,1) enabled cycles.
module decoder38_seq #(
  parameter int HOLD_W = 4,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_code,
  input  logic [HOLD_W-1:0] in_hold,
  output logic [7:0]        y,
  output logic              y_valid,
  output logic              busy,
  output logic [CNT_W-1:0]  done_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = 3 + HOLD_W;
  localparam logic [PW:0]       PONE = 1;
  localparam logic [HOLD_W-1:0] HONE = 1;
  localparam logic [CNT_W-1:0]  CONE = 1;

  typedef enum logic {IDLE, DRIVE} state_t;

  state_t            state_q, state_d;
  logic [EW-1:0]     mem_q [DEPTH];
  logic [EW-1:0]     mem_d [DEPTH];
  logic [PW:0]       wr_q, wr_d;
  logic [PW:0]       rd_q, rd_d;
  logic [HOLD_W-1:0] rem_q, rem_d;
  logic [7:0]        y_q, y_d;
  logic              yv_q, yv_d;
  logic [CNT_W-1:0]  done_q, done_d;

  logic              empty;
  logic              full;
  logic              push;
  logic              pop;
  logic [EW-1:0]     head;
  logic [2:0]        head_code;
  logic [HOLD_W-1:0] head_hold;
  logic [HOLD_W-1:0] head_rem;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[PW] != rd_q[PW]) &&
                 (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign push  = in_valid && !full;

  assign head      = mem_q[rd_q[PW-1:0]];
  assign head_code = head[EW-1:HOLD_W];
  assign head_hold = head[HOLD_W-1:0];
  assign head_rem  = (head_hold == '0) ? '0 : head_hold - HONE;

  assign in_ready = !full;
  assign y        = en ? y_q : 8'h00;
  assign y_valid  = en && yv_q;
  assign busy     = !empty || (state_q == DRIVE);
  assign done_cnt = done_q;

  // next-state: fifo push/pop and hold sequencing, frozen while en=0
  always_comb begin
    state_d = state_q;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    rem_d   = rem_q;
    y_d     = y_q;
    yv_d    = yv_q;
    done_d  = done_q;
    pop     = 1'b0;
    if (push) begin
      mem_d[wr_q[PW-1:0]] = {in_code, in_hold};
      wr_d = wr_q + PONE;
    end
    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = DRIVE;
          end
        end
        DRIVE: begin
          if (rem_q != '0) begin
            rem_d = rem_q - HONE;
          end else begin
            done_d = done_q + CONE;
            if (!empty) begin
              pop = 1'b1;
            end else begin
              y_d     = 8'h00;
              yv_d    = 1'b0;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (pop) begin
      rd_d  = rd_q + PONE;
      y_d   = 8'h01 << head_code;
      yv_d  = 1'b1;
      rem_d = head_rem;
    end
  end

  // state registers, async clear discards queue and current code
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mem_q   <= '{default: '0};
      wr_q    <= '0;
      rd_q    <= '0;
      rem_q   <= '0;
      y_q     <= 8'h00;
      yv_q    <= 1'b0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      rem_q   <= rem_d;
      y_q     <= y_d;
      yv_q    <= yv_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_decoder38_seq.sv
// Scoreboard bench for decoder38_seq.
// Second instance exercises a 2-bit done counter.
module tb_decoder38_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_code = '0;
  logic [3:0] in_hold = '0;
  logic [7:0] y;
  logic       y_valid;
  logic       busy;
  logic [7:0] done_cnt;

  logic       w_rst_n = 1'b0;
  logic       w_en = 1'b1;
  logic       w_in_valid = 1'b0;
  logic       w_in_ready;
  logic [2:0] w_in_code = '0;
  logic [3:0] w_in_hold = 4'd1;
  logic [7:0] w_y;
  logic       w_y_valid;
  logic       w_busy;
  logic [1:0] w_done_cnt;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int nvalid = 0;
  int vcyc [4096];
  logic [7:0] exp_q [$];
  logic [1:0] wseq [$];
  logic [1:0] w_prev = '0;

  decoder38_seq dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .in_hold(in_hold),
    .y(y), .y_valid(y_valid), .busy(busy),
    .done_cnt(done_cnt)
  );

  decoder38_seq #(.CNT_W(2)) dut_w (
    .clk(clk), .rst_n(w_rst_n), .en(w_en),
    .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_code(w_in_code), .in_hold(w_in_hold),
    .y(w_y), .y_valid(w_y_valid), .busy(w_busy),
    .done_cnt(w_done_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // rising edge: log accepted codes; falling edge: compare y
  always @(clk) begin
    logic [7:0] e;
    int hv;
    if (clk) begin
      if (rst_n && in_valid && in_ready) begin
        hv = (in_hold == 0) ? 1 : int'(in_hold);
        for (int k = 0; k < hv; k++)
          exp_q.push_back(8'h01 << in_code);
      end
    end else if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (y_valid) begin
        vcyc[nvalid] = cyc;
        nvalid++;
        if (exp_q.size() == 0) begin
          check("sb_extra", {24'h0, y}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("sb_y", {24'h0, y}, {24'h0, e});
        end
      end else begin
        check("y_idle", {24'h0, y}, 32'h0);
      end
    end
  end

  always @(negedge clk) begin
    if (w_rst_n && w_done_cnt != w_prev) begin
      wseq.push_back(w_done_cnt);
      w_prev = w_done_cnt;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] c,
                      input logic [3:0] h);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_code = c;
    in_hold = h;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
    end
    check("send_accept", {31'h0, acc}, 32'h1);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("idle_reached", {31'h0, busy}, 32'h0);
    tick();
  endtask

  int e0;
  int nv0;
  int base;
  int exp_w [5] = '{1, 2, 3, 0, 1};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_y", {24'h0, y}, 32'h0);
    check("rst_yv", {31'h0, y_valid}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {24'h0, done_cnt}, 32'h0);
    rst_n = 1'b1;
    w_rst_n = 1'b1;
    #1;
    check("rst_ready", {31'h0, in_ready}, 32'h1);
    tick();

    // sweep codes 0..7, hold 1, back to back
    nv0 = nvalid;
    send(3'd0, 4'd1);
    e0 = cyc;
    for (int c = 1; c < 8; c++) send(3'(c), 4'd1);
    wait_idle();
    check("sweep_lat", vcyc[nv0], e0 + 1);
    check("sweep_span", vcyc[nvalid-1] - vcyc[nv0], 7);
    check("sweep_n", nvalid - nv0, 8);
    check("sweep_done", {24'h0, done_cnt}, 8);
    check("sweep_sb", exp_q.size(), 0);

    // reset in the middle of a long hold
    send(3'd5, 4'd6);
    repeat (3) tick();
    check("pre_rst_y", {24'h0, y}, 32'h20);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_y", {24'h0, y}, 32'h0);
    check("mid_rst_yv", {31'h0, y_valid}, 32'h0);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check("mid_rst_done", {24'h0, done_cnt}, 32'h0);
    tick();
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", {31'h0, in_ready}, 32'h1);
    tick();
    check("post_rst_busy", {31'h0, busy}, 32'h0);

    // hold 4 then hold 0 with no gap
    nv0 = nvalid;
    send(3'd3, 4'd4);
    e0 = cyc;
    send(3'd6, 4'd0);
    wait_idle();
    check("hold_lat", vcyc[nv0], e0 + 1);
    check("hold_span", vcyc[nvalid-1] - vcyc[nv0], 4);
    check("hold_n", nvalid - nv0, 5);
    check("hold_done", {24'h0, done_cnt}, 2);
    check("hold_y_end", {24'h0, y}, 32'h0);

    // fill the fifo behind a long hold
    base = int'(done_cnt);
    send(3'd1, 4'd15);
    repeat (2) tick();
    send(3'd2, 4'd2);
    send(3'd3, 4'd1);
    in_valid = 1'b1;
    in_code = 3'd4;
    in_hold = 4'd3;
    repeat (3) begin
      @(negedge clk);
      check("full_ready", {31'h0, in_ready}, 32'h0);
      check("full_busy", {31'h0, busy}, 32'h1);
      tick();
    end
    send(3'd4, 4'd3);
    wait_idle();
    check("full_sb", exp_q.size(), 0);
    check("full_done", {24'h0, done_cnt}, base + 4);

    // pause en after two driven cycles
    nv0 = nvalid;
    send(3'd2, 4'd5);
    e0 = cyc;
    repeat (3) tick();
    en = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("pause_y", {24'h0, y}, 32'h0);
      check("pause_yv", {31'h0, y_valid}, 32'h0);
      check("pause_busy", {31'h0, busy}, 32'h1);
      tick();
    end
    en = 1'b1;
    wait_idle();
    check("en_n", nvalid - nv0, 5);
    check("en_lat", vcyc[nv0], e0 + 1);
    check("en_span", vcyc[nvalid-1] - vcyc[nv0], 7);
    check("en_sb", exp_q.size(), 0);

    // 2-bit done counter wrap
    w_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      w_in_code = 3'(i);
      @(negedge clk);
      check("w_ready", {31'h0, w_in_ready}, 32'h1);
      tick();
    end
    w_in_valid = 1'b0;
    repeat (6) tick();
    check("w_n", wseq.size(), 5);
    for (int i = 0; i < 5; i++)
      check("w_done_seq",
            (i < wseq.size()) ? {30'h0, wseq[i]} : 32'hff,
            exp_w[i]);
    check("w_busy", {31'h0, w_busy}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
